// File: rtl/compensation_mem_reader.sv
// ---------------------------------------------------------------------------
// compensation_mem_reader
//
// Read-side sequencer for the compensation weight memory. Once weight
// loading is complete and a start pulse arrives, it walks the columns
// 0..NUM_COL-1. For each column it reads the ROWS entries through a
// 1-cycle-latency read port, packs them into one column word and hands
// that word to the PE-array compensation loader over valid/ready.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             single-cycle request to begin a full column sweep
//   load_weight_done  load phase complete; deasserting it aborts a sweep
//   mem_ren           memory read enable
//   mem_raddr         memory read address (held while mem_ren=0)
//   mem_rdata         read data, valid the cycle after mem_ren
//   col_data          packed column word, row k at [k*DW +: DW]
//   col_idx           column index of col_data
//   col_valid         col_data/col_idx valid
//   col_ready         downstream accepts the column word
//   busy              high in every state except IDLE
//   done              one-cycle pulse after the last column is accepted
// ---------------------------------------------------------------------------
module compensation_mem_reader #(
   parameter int NUM_COL = 8,
   parameter int ROWS    = 3,
   parameter int DW      = 3,
   parameter int AW      = 5,
   parameter int CW      = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               load_weight_done,
   output logic               mem_ren,
   output logic [AW-1:0]      mem_raddr,
   input  logic [DW-1:0]      mem_rdata,
   output logic [ROWS*DW-1:0] col_data,
   output logic [CW-1:0]      col_idx,
   output logic               col_valid,
   input  logic               col_ready,
   output logic               busy,
   output logic               done
);

   // Row counter must also hold ROWS so the last slot index stays distinct.
   localparam int RW = $clog2(ROWS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_PRESENT,
      S_FINISH
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic [AW-1:0]      cur_addr;
   logic [AW-1:0]      raddr_hold;
   logic [ROWS*DW-1:0] col_data_q;
   logic               issue;

   // Read-return tracking: one cycle behind the issued read
   logic               rd_pend_p0;
   logic [RW-1:0]      rd_slot_p0;

   assign cur_addr = AW'(col) * AW'(ROWS) + AW'(row);
   assign issue    = (state == S_ISSUE);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      if ((state != S_IDLE) && !load_weight_done) begin
         // Losing the load-complete qualifier aborts the sweep outright.
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (start && load_weight_done) state_nxt = S_ISSUE;
            S_ISSUE:   if (row == RW'(ROWS - 1)) state_nxt = S_DRAIN;
            S_DRAIN:   state_nxt = S_PRESENT;
            S_PRESENT: begin
               if (col_ready) begin
                  state_nxt = (col == CW'(NUM_COL - 1)) ? S_FINISH : S_ISSUE;
               end
            end
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      mem_ren   = issue;
      mem_raddr = issue ? cur_addr : raddr_hold;
      col_data  = col_data_q;
      col_idx   = col;
      col_valid = (state == S_PRESENT);
      busy      = (state != S_IDLE);
      done      = (state == S_FINISH);
   end

   // ---------------- counters, address hold, read capture ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         raddr_hold <= '0;
         rd_pend_p0 <= 1'b0;
         rd_slot_p0 <= '0;
         col_data_q <= '0;
      end else begin
         rd_pend_p0 <= issue;
         rd_slot_p0 <= row;

         if (issue) begin
            raddr_hold <= cur_addr;
         end

         // Every slot is rewritten for each column, so no clearing is needed.
         if (rd_pend_p0) begin
            for (int k = 0; k < ROWS; k++) begin
               if (rd_slot_p0 == RW'(k)) begin
                  col_data_q[k*DW +: DW] <= mem_rdata;
               end
            end
         end

         if (state_nxt == S_IDLE) begin
            col <= '0;
            row <= '0;
         end else if (issue) begin
            row <= row + 1'b1;
         end else if ((state == S_PRESENT) && (state_nxt == S_ISSUE)) begin
            col <= col + 1'b1;
            row <= '0;
         end
      end
   end

endmodule

// File: tb/tb_compensation_mem_reader.sv
`timescale 1ns/1ps
module tb_compensation_mem_reader;

   localparam int NUM_COL = 8;
   localparam int ROWS    = 3;
   localparam int DW      = 3;
   localparam int AW      = 5;
   localparam int CW      = 3;
   localparam int DEPTH   = NUM_COL * ROWS;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               load_weight_done = 1'b0;
   logic               col_ready = 1'b0;
   logic               mem_ren;
   logic [AW-1:0]      mem_raddr;
   logic [DW-1:0]      mem_rdata;
   logic [ROWS*DW-1:0] col_data;
   logic [CW-1:0]      col_idx;
   logic               col_valid;
   logic               busy;
   logic               done;

   logic [DW-1:0]      mem [0:DEPTH-1];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   compensation_mem_reader #(
      .NUM_COL(NUM_COL), .ROWS(ROWS), .DW(DW), .AW(AW), .CW(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .load_weight_done(load_weight_done),
      .mem_ren(mem_ren),
      .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata),
      .col_data(col_data),
      .col_idx(col_idx),
      .col_valid(col_valid),
      .col_ready(col_ready),
      .busy(busy),
      .done(done)
   );

   // Synchronous read memory, 1-cycle latency
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem[mem_raddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mod8();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i % 8);
   endtask

   task automatic fill_zero();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({mem_ren, mem_raddr, col_data, col_idx, col_valid, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got ren=%b addr=%0d data=%h idx=%0d vld=%b busy=%b done=%b required all 0",
                  mem_ren, mem_raddr, col_data, col_idx, col_valid, busy, done);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_sweep();
      int cyc = 0, first_v = -1, done_cyc = -1, nren = 0, bad_addr = 0;
      bit seen7 = 0;
      fill_mod8();
      load_weight_done = 1'b1;
      col_ready = 1'b1;
      start = 1'b1;
      while (cyc < 60 && done_cyc < 0) begin
         tick();
         start = 1'b0;
         cyc++;
         if (mem_ren) begin
            if (mem_raddr !== AW'(nren)) bad_addr++;
            nren++;
         end
         if (col_valid && first_v < 0) begin
            first_v = cyc;
            tests_run++;
            if (col_idx !== 3'd0 || col_data !== 9'h088) begin
               tests_failed++;
               $display("FAIL sweep_col0: got idx=%0d data=%h required idx=0 data=088", col_idx, col_data);
            end
         end
         if (col_valid && col_idx == 3'd7) begin
            seen7 = 1;
            tests_run++;
            if (col_data !== 9'h1F5) begin
               tests_failed++;
               $display("FAIL sweep_col7: got data=%h required 1f5", col_data);
            end
         end
         if (done) done_cyc = cyc;
      end
      tests_run++;
      if (first_v != 5) begin
         tests_failed++;
         $display("FAIL sweep_first_valid_cycle: got %0d required 5", first_v);
      end
      tests_run++;
      if (!seen7) begin
         tests_failed++;
         $display("FAIL sweep_col7_seen: got 0 required 1");
      end
      tests_run++;
      if (done_cyc != 41) begin
         tests_failed++;
         $display("FAIL sweep_done_cycle: got %0d required 41", done_cyc);
      end
      tests_run++;
      if (nren != 24 || bad_addr != 0) begin
         tests_failed++;
         $display("FAIL sweep_reads: got %0d reads, %0d bad addresses required 24 reads, 0 bad", nren, bad_addr);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sweep_idle_after_done: got busy=%b required 0", busy);
      end
   endtask

   task automatic test_backpressure();
      int n = 0, bad_data = 0, bad_ren = 0, ndone = 0;
      fill_zero();
      mem[9]  = 3'd3;
      mem[10] = 3'd2;
      mem[11] = 3'd7;
      load_weight_done = 1'b1;
      col_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (n < 40 && !(mem_ren && mem_raddr == 5'd11)) begin
         tick();
         n++;
      end
      col_ready = 1'b0;
      n = 0;
      while (n < 6 && !col_valid) begin
         tick();
         n++;
      end
      tests_run++;
      if (col_valid !== 1'b1 || col_idx !== 3'd3) begin
         tests_failed++;
         $display("FAIL bp_present_col3: got vld=%b idx=%0d required vld=1 idx=3", col_valid, col_idx);
      end
      for (int i = 0; i < 10; i++) begin
         if (col_valid !== 1'b1 || col_data !== 9'h1D3 || col_idx !== 3'd3) bad_data++;
         if (mem_ren !== 1'b0) bad_ren++;
         tick();
      end
      tests_run++;
      if (bad_data != 0) begin
         tests_failed++;
         $display("FAIL bp_hold_stable: got %0d unstable cycles (last data=%h) required 0 (data=1d3)", bad_data, col_data);
      end
      tests_run++;
      if (bad_ren != 0) begin
         tests_failed++;
         $display("FAIL bp_no_read_in_stall: got %0d read cycles required 0", bad_ren);
      end
      col_ready = 1'b1;
      tick();
      tests_run++;
      if (col_valid !== 1'b0 || mem_ren !== 1'b1 || mem_raddr !== 5'd12) begin
         tests_failed++;
         $display("FAIL bp_next_issue: got vld=%b ren=%b addr=%0d required vld=0 ren=1 addr=12",
                  col_valid, mem_ren, mem_raddr);
      end
      n = 0;
      while (n < 40 && busy) begin
         if (done) ndone++;
         tick();
         n++;
      end
      tests_run++;
      if (ndone != 1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_sweep_end: got done=%0d busy=%b required done=1 busy=0", ndone, busy);
      end
   endtask

   task automatic test_gating();
      int ndone = 0, done_cyc = -1;
      fill_mod8();
      col_ready = 1'b1;
      load_weight_done = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || mem_ren !== 1'b0) begin
         tests_failed++;
         $display("FAIL gate_no_load_done: got busy=%b ren=%b required 0 0", busy, mem_ren);
      end
      tick();
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL gate_stays_idle: got busy=%b required 0", busy);
      end
      load_weight_done = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
         start = (cyc == 7);
         tick();
      end
      start = 1'b0;
      tests_run++;
      if (ndone != 1 || done_cyc != 41) begin
         tests_failed++;
         $display("FAIL gate_second_start: got %0d done pulses, last at %0d required 1 at 41", ndone, done_cyc);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL gate_end_idle: got busy=%b required 0", busy);
      end
   endtask

   task automatic test_abort();
      int n = 0, ndone = 0;
      fill_mod8();
      col_ready = 1'b1;
      load_weight_done = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (n < 40 && !(mem_ren && mem_raddr == 5'd6)) begin
         tick();
         n++;
      end
      load_weight_done = 1'b0;
      tick();
      tests_run++;
      if (busy !== 1'b0 || mem_ren !== 1'b0 || col_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_idle: got busy=%b ren=%b vld=%b required 0 0 0", busy, mem_ren, col_valid);
      end
      for (int i = 0; i < 10; i++) begin
         if (done) ndone++;
         tick();
      end
      tests_run++;
      if (ndone != 0) begin
         tests_failed++;
         $display("FAIL abort_no_done: got %0d done pulses required 0", ndone);
      end
      load_weight_done = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if (mem_ren !== 1'b1 || mem_raddr !== 5'd0) begin
         tests_failed++;
         $display("FAIL abort_restart: got ren=%b addr=%0d required ren=1 addr=0", mem_ren, mem_raddr);
      end
      n = 0;
      while (n < 50 && busy) begin
         tick();
         n++;
      end
   endtask

   task automatic test_async_reset();
      int n = 0, cyc = 0, first_v = -1;
      fill_mod8();
      col_ready = 1'b1;
      load_weight_done = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (n < 40 && !(col_valid && col_idx == 3'd5)) begin
         tick();
         n++;
      end
      tests_run++;
      if (col_data !== 9'h047) begin
         tests_failed++;
         $display("FAIL rst_pre_col5: got data=%h required 047", col_data);
      end
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({mem_ren, mem_raddr, col_data, col_idx, col_valid, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL rst_async_outputs: got ren=%b addr=%0d data=%h idx=%0d vld=%b busy=%b done=%b required all 0",
                  mem_ren, mem_raddr, col_data, col_idx, col_valid, busy, done);
      end
      tick();
      rst = 1'b0;
      tick();
      start = 1'b1;
      while (cyc < 10 && first_v < 0) begin
         tick();
         start = 1'b0;
         cyc++;
         if (col_valid) first_v = cyc;
      end
      tests_run++;
      if (first_v != 5 || col_idx !== 3'd0 || col_data !== 9'h088) begin
         tests_failed++;
         $display("FAIL rst_restart_col0: got cycle=%0d idx=%0d data=%h required cycle=5 idx=0 data=088",
                  first_v, col_idx, col_data);
      end
      n = 0;
      while (n < 50 && busy) begin
         tick();
         n++;
      end
   endtask

   task automatic test_sparse();
      int n = 0, ncols = 0, bad = 0;
      logic [ROWS*DW-1:0] expv;
      fill_zero();
      mem[9] = 3'd5;
      col_ready = 1'b1;
      load_weight_done = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (n < 60 && busy) begin
         if (col_valid) begin
            expv = (col_idx == 3'd3) ? 9'h005 : 9'h000;
            ncols++;
            tests_run++;
            if (col_data !== expv) begin
               tests_failed++;
               bad++;
               $display("FAIL sparse_col%0d: got data=%h required %h", col_idx, col_data, expv);
            end
         end
         tick();
         n++;
      end
      tests_run++;
      if (ncols != NUM_COL) begin
         tests_failed++;
         $display("FAIL sparse_col_count: got %0d required %0d", ncols, NUM_COL);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_backpressure();
      test_gating();
      test_abort();
      test_async_reset();
      test_sparse();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
